// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encoding and the common word-level constants.
package hilo_mdu_ctrl_pkg;

  localparam int REG_W = 32;
  typedef logic [REG_W-1:0] reg_bus_t;

  localparam reg_bus_t ZERO_WORD    = '0;
  localparam logic     WRITE_ENABLE = 1'b1;

  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_DIV    = 3'd2,
    S_DIVFIX = 3'd3,
    S_DONE   = 3'd4
  } mdu_state_e;

  // Multi-cycle ops (multiply and divide) hold the pipeline; MTHI/MTLO do not.
  function automatic logic op_is_multicycle(input logic [2:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_if.sv
// EX-stage request bundle in, HI/LO write bundle and pipeline hold out.
// Handshake: a request is taken only in the cycle where start_i=1, the
// sequencer is idle and flush_i=0; while stall_req_o=1 the EX stage must
// hold its request stable. hilo_we_o is a one-cycle strobe qualifying hi_o/lo_o.
interface hilo_mdu_ctrl_if #(parameter int DATA_W = 32);
  logic              start_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic [DATA_W-1:0] hi_cur_i;
  logic [DATA_W-1:0] lo_cur_i;
  logic              flush_i;
  logic              hilo_we_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              stall_req_o;
  logic              busy_o;

  modport master (
    output start_i, op_i, src1_i, src2_i, hi_cur_i, lo_cur_i, flush_i,
    input  hilo_we_o, hi_o, lo_o, stall_req_o, busy_o
  );

  modport slave (
    input  start_i, op_i, src1_i, src2_i, hi_cur_i, lo_cur_i, flush_i,
    output hilo_we_o, hi_o, lo_o, stall_req_o, busy_o
  );
endinterface

// File: rtl/hilo_mdu_ctrl_div_core.sv
// 32-step restoring divider on unsigned magnitudes. start_i loads the
// operands; one quotient bit is produced per cycle. done_o is high in the
// cycle performing the final step, so quot_o/rem_o are valid the cycle after.
module mdu_div_core #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  quot_q, rem_q, divisor_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [W:0]    rem_shift;
  logic [W+1:0]  diff;
  logic          ge;

  // One restoring step: shift in the next dividend bit, trial subtract.
  always_comb begin
    rem_shift = {rem_q, quot_q[W-1]};
    diff      = {1'b0, rem_shift} - {2'b00, divisor_q};
    ge        = ~diff[W+1];
  end

  // Operand load, per-cycle step and step counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else if (abort_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      quot_q    <= dividend_i;
      rem_q     <= '0;
      divisor_q <= divisor_i;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= ge ? diff[W-1:0] : rem_shift[W-1:0];
      quot_q <= {quot_q[W-2:0], ge};
      cnt_q  <= cnt_q + 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  assign done_o = busy_q && (cnt_q == LAST);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply/divide sequencer. Owns every write into the HI/LO pair:
// MTHI/MTLO write the next cycle, multiplies after MUL_LAT cycles, divides
// after 34 cycles. The pipeline is held while a multi-cycle op is in flight.
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic           cpu_clk_50M,
  input  logic           cpu_rst,
  hilo_mdu_ctrl_if.slave bus,
  output mdu_state_e     dbg_state_o
);
  localparam logic [2:0] MUL_LAST = 3'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam int         MSB      = DATA_W - 1;

  mdu_state_e          state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                we_q, we_d, busy_q;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*DATA_W-1:0] prod_q, prod_d, prod_u;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   src1_q, mag_a, mag_b, core_quot, core_rem, quot_fix, rem_fix;
  logic                neg_quot_q, neg_rem_q, dz_q, a_neg, b_neg;
  logic                is_mul, is_div, is_mt, accept, core_done;

  // Request decode and operand preparation (product, divide magnitudes).
  always_comb begin
    is_mul = (bus.op_i == MDU_MULT) || (bus.op_i == MDU_MULTU);
    is_div = (bus.op_i == MDU_DIV)  || (bus.op_i == MDU_DIVU);
    is_mt  = (bus.op_i == MDU_MTHI) || (bus.op_i == MDU_MTLO);
    accept = bus.start_i && (state_q == S_IDLE) && !bus.flush_i && (is_mul || is_div || is_mt);
    prod_s = $signed({{DATA_W{bus.src1_i[MSB]}}, bus.src1_i}) *
             $signed({{DATA_W{bus.src2_i[MSB]}}, bus.src2_i});
    prod_u = {{DATA_W{1'b0}}, bus.src1_i} * {{DATA_W{1'b0}}, bus.src2_i};
    prod_d = (bus.op_i == MDU_MULT) ? $unsigned(prod_s) : prod_u;
    a_neg  = (bus.op_i == MDU_DIV) && bus.src1_i[MSB];
    b_neg  = (bus.op_i == MDU_DIV) && bus.src2_i[MSB];
    mag_a  = a_neg ? ('0 - bus.src1_i) : bus.src1_i;
    mag_b  = b_neg ? ('0 - bus.src2_i) : bus.src2_i;
  end

  mdu_div_core #(.W(DATA_W)) u_div (
    .clk_i      (cpu_clk_50M),
    .rst_i      (cpu_rst),
    .start_i    (accept && is_div),
    .abort_i    (bus.flush_i),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .done_o     (core_done),
    .quot_o     (core_quot),
    .rem_o      (core_rem)
  );

  // Sign fix-up; a zero divisor bypasses it with the fixed result.
  always_comb begin
    quot_fix = dz_q ? '1     : (neg_quot_q ? ('0 - core_quot) : core_quot);
    rem_fix  = dz_q ? src1_q : (neg_rem_q  ? ('0 - core_rem)  : core_rem);
  end

  // Next-state and write-data logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (is_mt) begin
            we_d = WRITE_ENABLE;
            hi_d = (bus.op_i == MDU_MTHI) ? bus.src1_i : bus.hi_cur_i;
            lo_d = (bus.op_i == MDU_MTLO) ? bus.src1_i : bus.lo_cur_i;
          end else if (is_mul) begin
            if (MUL_LAT == 1) begin
              state_d = S_DONE;
              we_d    = WRITE_ENABLE;
              hi_d    = prod_d[2*DATA_W-1:DATA_W];
              lo_d    = prod_d[DATA_W-1:0];
            end else begin
              state_d = S_MUL;
            end
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          state_d = S_DONE;
          we_d    = WRITE_ENABLE;
          hi_d    = prod_q[2*DATA_W-1:DATA_W];
          lo_d    = prod_q[DATA_W-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (bus.flush_i)    state_d = S_IDLE;
        else if (core_done) state_d = S_DIVFIX;
      end
      S_DIVFIX: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          we_d    = WRITE_ENABLE;
          hi_d    = rem_fix;
          lo_d    = quot_fix;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, write strobe/data and busy registers.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      hi_q    <= ZERO_WORD;
      lo_q    <= ZERO_WORD;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Operand capture on accept: product, raw dividend and sign flags.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      prod_q     <= '0;
      src1_q     <= ZERO_WORD;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else if (accept) begin
      if (is_mul) prod_q <= prod_d;
      if (is_div) begin
        src1_q     <= bus.src1_i;
        neg_quot_q <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
        dz_q       <= (bus.src2_i == '0);
      end
    end
  end

  assign bus.stall_req_o = (accept && op_is_multicycle(bus.op_i)) ||
                           (!bus.flush_i && ((state_q == S_MUL) || (state_q == S_DIV) ||
                                             (state_q == S_DIVFIX)));
  assign bus.hilo_we_o   = we_q;
  assign bus.hi_o        = hi_q;
  assign bus.lo_o        = lo_q;
  assign bus.busy_o      = busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: expected HI/LO writes (with the cycle
// they must land in) are queued at issue time and popped by a monitor.
module tb_hilo_mdu_ctrl;
  import hilo_mdu_ctrl_pkg::*;

  localparam int LAT_MUL = 3;
  localparam int LAT_DIV = 34;
  localparam int LAT_MT  = 1;

  logic       cpu_clk_50M = 1'b0;
  logic       cpu_rst     = 1'b1;
  mdu_state_e dbg_state;
  int         cyc     = 0;
  int         n_check = 0;
  int         n_fail  = 0;
  logic [95:0] exp_q[$];

  hilo_mdu_ctrl_if #(.DATA_W(32)) bus ();

  hilo_mdu_ctrl #(.DATA_W(32), .MUL_LAT(LAT_MUL)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock and cycle counter.
  always #5 cpu_clk_50M = ~cpu_clk_50M;
  always @(posedge cpu_clk_50M) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge cpu_clk_50M) begin
    if (!cpu_rst && bus.hilo_we_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        check("write_cycle", cyc, e[95:64]);
        check("write_hi", bus.hi_o, e[63:32]);
        check("write_lo", bus.lo_o, e[31:0]);
      end
    end
  end

  // Issue one op at the current cycle (caller sits just after a rising edge),
  // check stall/busy every cycle, and return just after the edge following
  // the write cycle. fl_done pulses flush in the write cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] eh, input logic [31:0] el,
                        input bit fl_done);
    logic stall_op;
    stall_op = (op >= MDU_MULT) && (op <= MDU_DIVU);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    if (op >= MDU_MULT && op <= MDU_MTLO) exp_q.push_back({32'(cyc + lat), eh, el});
    @(negedge cpu_clk_50M);
    check("stall_accept", {31'd0, bus.stall_req_o}, {31'd0, stall_op});
    for (int i = 1; i <= lat; i++) begin
      @(posedge cpu_clk_50M); #1;
      bus.start_i = 1'b0;
      bus.op_i    = MDU_NOP;
      if (fl_done && i == lat) bus.flush_i = 1'b1;
      @(negedge cpu_clk_50M);
      check("stall_run", {31'd0, bus.stall_req_o}, {31'd0, (stall_op && i < lat)});
      if (i == 1) check("busy_run", {31'd0, bus.busy_o}, {31'd0, stall_op});
    end
    @(posedge cpu_clk_50M); #1;
    bus.flush_i = 1'b0;
  endtask

  // Directed stimulus.
  initial begin
    bus.start_i = 1'b0; bus.op_i = MDU_NOP; bus.src1_i = '0; bus.src2_i = '0;
    bus.hi_cur_i = '0;  bus.lo_cur_i = '0;  bus.flush_i = 1'b0;
    repeat (3) @(posedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    check("rst_we", {31'd0, bus.hilo_we_o}, 32'd0);
    check("rst_hi", bus.hi_o, 32'h0);
    check("rst_lo", bus.lo_o, 32'h0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    @(posedge cpu_clk_50M); #1;
    cpu_rst = 1'b0;
    @(posedge cpu_clk_50M); #1;

    run_op(MDU_MULT,  32'hFFFFFFFF, 32'd2, LAT_MUL, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'd2, LAT_MUL, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op(MDU_MULT,  32'hFFFFFFFD, 32'd5, LAT_MUL, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    bus.hi_cur_i = 32'h0BADF00D;
    bus.lo_cur_i = 32'hCAFEBABE;
    run_op(MDU_MTHI, 32'h12345678, 32'd0, LAT_MT, 32'h12345678, 32'hCAFEBABE, 1'b0);
    run_op(MDU_MTLO, 32'hA5A5A5A5, 32'd0, LAT_MT, 32'h0BADF00D, 32'hA5A5A5A5, 1'b0);
    run_op(MDU_DIV,  32'hFFFFFFF9, 32'd2, LAT_DIV, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(MDU_DIVU, 32'd100, 32'd0, LAT_DIV, 32'd100, 32'hFFFFFFFF, 1'b0);
    run_op(MDU_DIV,  32'h80000000, 32'hFFFFFFFF, LAT_DIV, 32'h0, 32'h80000000, 1'b0);
    run_op(MDU_DIVU, 32'd100, 32'd7, LAT_DIV, 32'd2, 32'd14, 1'b0);
    run_op(MDU_DIV,  32'd7, 32'hFFFFFFFE, LAT_DIV, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_op(MDU_DIV,  32'hFFFFFFF9, 32'd0, LAT_DIV, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    run_op(MDU_NOP,  32'd5, 32'd5, LAT_MT, 32'h0, 32'h0, 1'b0);
    run_op(3'd7,     32'd5, 32'd5, LAT_MT, 32'h0, 32'h0, 1'b0);
    run_op(MDU_MULT, 32'd6, 32'd7, LAT_MUL, 32'h0, 32'd42, 1'b1);

    // Flush a divide at N+5, then start a multiply at N+6.
    bus.start_i = 1'b1; bus.op_i = MDU_DIV; bus.src1_i = 32'd50; bus.src2_i = 32'd3;
    @(posedge cpu_clk_50M); #1;
    bus.start_i = 1'b0; bus.op_i = MDU_NOP;
    repeat (4) begin @(posedge cpu_clk_50M); #1; end
    bus.flush_i = 1'b1;
    @(negedge cpu_clk_50M);
    check("flush_stall", {31'd0, bus.stall_req_o}, 32'd0);
    @(posedge cpu_clk_50M); #1;
    bus.flush_i = 1'b0;
    check("flush_busy", {31'd0, bus.busy_o}, 32'd0);
    check("flush_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    run_op(MDU_MULT, 32'd3, 32'd4, LAT_MUL, 32'h0, 32'd12, 1'b0);

    // Reset at N+10 of a divide: outputs cleared, no write afterwards.
    bus.start_i = 1'b1; bus.op_i = MDU_DIV; bus.src1_i = 32'd99; bus.src2_i = 32'd9;
    @(posedge cpu_clk_50M); #1;
    bus.start_i = 1'b0; bus.op_i = MDU_NOP;
    repeat (9) begin @(posedge cpu_clk_50M); #1; end
    cpu_rst = 1'b1;
    @(negedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    check("midrst_we", {31'd0, bus.hilo_we_o}, 32'd0);
    check("midrst_hi", bus.hi_o, 32'h0);
    check("midrst_lo", bus.lo_o, 32'h0);
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("midrst_stall", {31'd0, bus.stall_req_o}, 32'd0);
    @(posedge cpu_clk_50M); #1;
    cpu_rst = 1'b0;
    repeat (40) begin @(posedge cpu_clk_50M); #1; end
    run_op(MDU_MTLO, 32'h5555AAAA, 32'd0, LAT_MT, 32'h0BADF00D, 32'h5555AAAA, 1'b0);

    repeat (2) @(posedge cpu_clk_50M);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns all writes into the HI/LO register pair.
- Sits in EX, beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs the multiply delay or the 32-step restoring divide.
- Holds the pipeline through stall_req_o, then issues a single-cycle write (hilo_we_o, hi_o, lo_o) to the hilo register.

Parameters:
- DATA_W, 32, operand and HI/LO width; only 32 is supported.
- MUL_LAT, 3, cycles from multiply accept to write; legal range 1..7.

Ports:
- cpu_clk_50M  in  1  system clock; all state updates on rising edge.
- cpu_rst  in  1  synchronous reset, active-high.
- start_i  in  1  operation request, valid with op_i/src1_i/src2_i.
- op_i  in  3  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- src1_i  in  DATA_W  multiplicand/dividend; also the MTHI/MTLO data.
- src2_i  in  DATA_W  multiplier/divisor.
- hi_cur_i  in  DATA_W  current HI from the hilo register.
- lo_cur_i  in  DATA_W  current LO from the hilo register.
- flush_i  in  1  exception/flush; aborts the in-flight op.
- hilo_we_o  out  1  one-cycle write strobe to the hilo register.
- hi_o  out  DATA_W  HI write data.
- lo_o  out  DATA_W  LO write data.
- stall_req_o  out  1  pipeline hold request.
- busy_o  out  1  registered; high while state != IDLE.

Behaviour:
- Reset (cpu_rst=1 at an edge): state IDLE, counter 0, hilo_we_o=0, hi_o=0, lo_o=0, busy_o=0, all datapath registers 0. Reset mid-operation discards the op; no write occurs.
- States: IDLE, MUL, DIV, DIVFIX, DONE.
- Accept rule: start_i=1 in IDLE, flush_i=0, op 1..6. start_i outside IDLE is ignored. NOP/reserved ops are ignored.
- MTHI (cycle N): next edge hilo_we_o=1, hi_o=src1_i, lo_o=lo_cur_i; state stays IDLE; no stall.
- MTLO: same as MTHI with lo_o=src1_i and hi_o=hi_cur_i.
- MULT/MULTU accepted at cycle N:
  - 64-bit product registered at the N edge; signed for MULT, unsigned for MULTU.
  - State MUL; counter counts MUL_LAT-1 cycles, then DONE.
  - hilo_we_o=1 during cycle N+MUL_LAT with hi_o=product[63:32], lo_o=product[31:0].
- DIV/DIVU accepted at cycle N:
  - Latch operand magnitudes (signed DIV only) and sign flags; state DIV, counter=0.
  - DIV: one restoring step per cycle (shift, trial subtract, set quotient bit); 32 cycles, N+1..N+32.
  - DIVFIX (N+33): negate quotient if operand signs differ; remainder takes the dividend's sign.
  - DONE (N+34): hilo_we_o=1, hi_o=remainder, lo_o=quotient.
- Divide by zero: fixed result hi_o=src1_i as latched, lo_o=0xFFFFFFFF; sign fix skipped; same latency.
- Signed edge case: 0x80000000/-1 gives lo=0x80000000, hi=0 (wrap, no trap).
- stall_req_o is combinational:
  - High when (start_i & IDLE & op in 1..4 & !flush_i), or state in {MUL, DIV, DIVFIX}.
  - Low in DONE, so the pipeline advances in the same cycle as the write.
- DONE lasts exactly one cycle, then returns to IDLE. hilo_we_o is 0 in every other cycle. hi_o/lo_o hold their last value when not writing.
- flush_i=1 in any non-IDLE state: next edge goes to IDLE with no write; stall_req_o drops combinationally in that cycle.
- flush_i together with start_i: nothing accepted.
- flush_i in DONE: the write still completes, since the result is already committed.

Decomposition:
- Shared define header holds: the op-code constants (MDU_NOP..MDU_MTLO), the state encodings, and REG_BUS/ZERO_WORD/WRITE_ENABLE reused from existing defines.
- One natural sub-module: mdu_div_core, the 32-step restoring divider with start/done, magnitude-in, raw quotient/remainder out.
- Sign handling, multiply and sequencing stay in hilo_mdu_ctrl.

Test Plan:
- Reset mid-DIV: assert cpu_rst at cycle N+10 -> all outputs 0, busy_o=0 next cycle, no hilo_we_o pulse ever.
- MULT src1=0xFFFFFFFF, src2=2, MUL_LAT=3 -> stall_req_o high cycles N..N+2, write in N+3 with hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands -> write in N+3 with hi=0x00000001, lo=0xFFFFFFFE.
- DIV src1=-7 (0xFFFFFFF9), src2=2 -> single write at N+34 with lo=0xFFFFFFFD, hi=0xFFFFFFFF; stall_req_o low in N+34.
- DIVU src1=100, src2=0 -> write at N+34 with hi=100, lo=0xFFFFFFFF.
- MTHI src1=0x12345678 with lo_cur_i=0xCAFEBABE -> write at N+1 with hi=0x12345678, lo=0xCAFEBABE, stall_req_o never high.
- DIV with flush_i pulsed at N+5 -> no write, state IDLE at N+6; a new MULT started at N+6 completes normally.
